change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Pays out a change amount as physical coins; the output-side counterpart of the coin-acceptance path.
- Accepts an amount in units of 100 from the coffee selection/subtraction logic.
- Drives coin-eject solenoid requests one coin at a time, with an acknowledge handshake from the coin mechanism, a minimum inter-coin gap, and a timeout fault.
- Sits between the change computation and the board's coin-return hardware; `remaining` can feed the existing 7-segment display path.

Parameters:
- AMOUNT_W, 4: width of the amount and `remaining`, in 100-units.
- ACK_TIMEOUT, 25_000_000: maximum cycles an eject request waits for `coin_ack` before a fault.
- GAP_CYCLES, 12_500_000: idle cycles after each acknowledged coin before the next eject.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- change_valid  in  1  request to dispense `change_amount`
- change_amount  in  AMOUNT_W  amount to return, in 100-units
- change_ready  out  1  high in IDLE; a request is accepted only when `change_valid` and `change_ready` are both high
- eject_500  out  1  request to drop one 500 coin
- eject_100  out  1  request to drop one 100 coin
- coin_ack  in  1  mechanism confirms the currently requested coin dropped
- remaining  out  AMOUNT_W  amount not yet dispensed
- done  out  1  one-cycle pulse when payout completes
- fault  out  1  sticky; ack timeout occurred

Behaviour:
- Interface (already decided): one clock, `clock`; `reset` is synchronous and active-high.
- Reset values and reset priority:
  - Reset wins over everything, including mid-payout.
  - Next cycle: state = IDLE, eject_500 = 0, eject_100 = 0, remaining = 0, done = 0, fault = 0, timer = 0.
  - change_ready = 1 (decoded from state == IDLE).
- States: IDLE, EJECT, GAP, DONE, FAULT.
- IDLE:
  - Accept on cycle N when change_valid && change_ready.
  - Amount == 0: state = DONE at N+1.
  - Otherwise: remaining = change_amount, coin select latched, state = EJECT at N+1.
  - `change_valid` when not ready is ignored, and is not queued.
- Coin select, latched on entry to EJECT:
  - 500 if remaining >= 5, else 100.
  - eject_500/eject_100 are decoded from state == EJECT and the latched select.
  - Exactly one eject output is high in EJECT; both are 0 in every other state.
- EJECT:
  - Timer increments each cycle.
  - `coin_ack` sampled high: remaining decreases by 5 or 1; state = GAP next cycle, so the eject drops the cycle after the ack.
  - Timer reaches ACK_TIMEOUT-1 with no ack: state = FAULT.
  - Ack in the same cycle as the timeout: ack wins.
- GAP:
  - Counts GAP_CYCLES cycles with ejects low; `coin_ack` is ignored.
  - Then: remaining == 0 → DONE; otherwise → EJECT with a new select.
- DONE: done = 1 for exactly one cycle, then → IDLE.
- FAULT:
  - fault = 1, ejects low, change_ready = 0.
  - `remaining` holds the undispensed amount.
  - Only reset exits.
- Arithmetic:
  - The subtraction never underflows, because a 500 is selected only when remaining >= 5.
  - Timer width is $clog2 of max(ACK_TIMEOUT, GAP_CYCLES) + 1.
- Latency: accept at N → eject high at N+1. Minimum per-coin period = 1 cycle + ack wait + GAP_CYCLES.

Optional Feature:
- Macro: COIN_500_EN.
- Defined: greedy payout, using 500 coins while remaining >= 5, then 100 coins.
- Undefined:
  - eject_500 is tied to 0.
  - Every coin is a 100, so the number of eject_100 cycles equals the amount.
  - Port list is unchanged.

Decomposition:
- Shared package coffee_pkg holds:
  - `dispense_state_t` enum (IDLE, EJECT, GAP, DONE, FAULT).
  - `COIN_100_UNITS = 1`, `COIN_500_UNITS = 5`, default `AMOUNT_W`.
  - `coin_sel_t` (SEL_100, SEL_500).
- One sub-module, cycle_timer:
  - Loadable up-counter with clear and terminal-count compare.
  - Shared by the EJECT timeout and the GAP count.

Test Plan (ACK_TIMEOUT=8, GAP_CYCLES=3):
- COIN_500_EN, amount 7, ack 2 cycles after each eject rises → eject_500 ×1, then eject_100 ×2; remaining 7→2→1→0; each gap is 3 cycles; one done pulse; fault = 0.
- Amount 0 accepted at N → done = 1 at N+1 only; no ejects; change_ready back to 1 at N+2.
- Amount 7, never ack → 8 cycles of eject_500, then fault = 1, ejects 0, remaining = 7; later change_valid ignored (change_ready = 0) until reset clears everything.
- Reset asserted mid-EJECT with amount 3 → next cycle ejects 0, remaining 0, change_ready 1; a new request of 1 then completes normally.
- change_valid during GAP with amount 9, and coin_ack pulsed during GAP → both ignored; payout of the original amount 2 continues; remaining is unaffected.
- COIN_500_EN undefined, amount 6 → six eject_100 handshakes; eject_500 never high; remaining 6→0; one done pulse.

Source files
------------

// File: rtl/coffee_pkg.sv
// Shared types and constants for the coffee machine money paths.
// Amounts are counted in 100-units: a 100 coin is 1 unit, a 500 coin is 5 units.
package coffee_pkg;

  localparam int DEFAULT_AMOUNT_W = 4;
  localparam int COIN_100_UNITS   = 1;
  localparam int COIN_500_UNITS   = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EJECT = 3'd1,
    GAP   = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } dispense_state_t;

  typedef enum logic {
    SEL_100 = 1'b0,
    SEL_500 = 1'b1
  } coin_sel_t;

endpackage

// File: rtl/change_dispenser_cycle_timer.sv
// cycle_timer: loadable up-counter with clear and terminal-count compare.
// clear has priority over load, load over count enable. tc_o is a pure
// compare of the current count against tc_value_i, so the owner can switch
// the terminal value from cycle to cycle.
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] tc_value_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear, then load, then increment.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_value_i;
    end else if (en_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == tc_value_i);

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount one coin at a time.
// Each coin is requested on eject_500/eject_100 until coin_ack, followed by a
// fixed idle gap. A missing ack within ACK_TIMEOUT cycles parks the block in
// FAULT until reset.
// Build option: define COIN_500_EN for greedy 500/100 payout; without it every
// coin is a 100 and eject_500 is tied low.
module change_dispenser
  import coffee_pkg::*;
#(
  parameter int AMOUNT_W    = DEFAULT_AMOUNT_W,
  parameter int ACK_TIMEOUT = 25_000_000,
  parameter int GAP_CYCLES  = 12_500_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                change_valid,
  input  logic [AMOUNT_W-1:0] change_amount,
  output logic                change_ready,
  output logic                eject_500,
  output logic                eject_100,
  input  logic                coin_ack,
  output logic [AMOUNT_W-1:0] remaining,
  output logic                done,
  output logic                fault
);

  localparam int MAX_CYCLES = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TIMER_W    = $clog2(MAX_CYCLES) + 1;
  localparam logic [TIMER_W-1:0] ACK_LAST = TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'(GAP_CYCLES - 1);

  dispense_state_t     state_q, state_d;
  coin_sel_t           sel_q, sel_d;
  coin_sel_t           next_sel;
  logic [AMOUNT_W-1:0] remaining_q, remaining_d;
  logic [AMOUNT_W-1:0] coin_units;

  logic                timer_clear;
  logic                timer_en;
  logic                timer_tc;
  logic [TIMER_W-1:0]  timer_tc_value;

`ifdef COIN_500_EN
  // The select is latched on every entry to EJECT: from IDLE it looks at the
  // requested amount, from GAP at what is still owed.
  logic [AMOUNT_W-1:0] select_src;
  assign select_src = (state_q == IDLE) ? change_amount : remaining_q;
  assign next_sel   = (select_src >= AMOUNT_W'(COIN_500_UNITS)) ? SEL_500 : SEL_100;
`else
  assign next_sel   = SEL_100;
`endif

  // A 500 is only ever selected with at least 5 units owed, so this never underflows.
  assign coin_units = (sel_q == SEL_500) ? AMOUNT_W'(COIN_500_UNITS)
                                         : AMOUNT_W'(COIN_100_UNITS);

  // Next-state, payout bookkeeping and coin select.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (change_valid) begin
          if (change_amount == '0) begin
            state_d = DONE;
          end else begin
            remaining_d = change_amount;
            sel_d       = next_sel;
            state_d     = EJECT;
          end
        end
      end
      EJECT: begin
        // An ack arriving on the timeout cycle still counts as a delivered coin.
        if (coin_ack) begin
          remaining_d = remaining_q - coin_units;
          state_d     = GAP;
        end else if (timer_tc) begin
          state_d = FAULT;
        end
      end
      GAP: begin
        if (timer_tc) begin
          if (remaining_q == '0) begin
            state_d = DONE;
          end else begin
            sel_d   = next_sel;
            state_d = EJECT;
          end
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // One timer serves both the ack timeout and the gap; it restarts on every
  // state change so each EJECT/GAP visit counts from zero.
  always_comb begin
    timer_clear    = (state_d != state_q);
    timer_en       = (state_q == EJECT) || (state_q == GAP);
    timer_tc_value = (state_q == EJECT) ? ACK_LAST : GAP_LAST;
  end

  cycle_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk          (clock),
    .srst         (reset),
    .clear_i      (timer_clear),
    .load_i       (1'b0),
    .load_value_i ('0),
    .en_i         (timer_en),
    .tc_value_i   (timer_tc_value),
    .tc_o         (timer_tc)
  );

  // State, select and remaining-amount registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= SEL_100;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      remaining_q <= remaining_d;
    end
  end

  assign change_ready = (state_q == IDLE);
  assign eject_100    = (state_q == EJECT) && (sel_q == SEL_100);
`ifdef COIN_500_EN
  assign eject_500    = (state_q == EJECT) && (sel_q == SEL_500);
`else
  assign eject_500    = 1'b0;
`endif
  assign remaining    = remaining_q;
  assign done         = (state_q == DONE);
  assign fault        = (state_q == FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser (ACK_TIMEOUT=8, GAP_CYCLES=3, AMOUNT_W=4).
// The stimulus side pushes the expected coin/done/fault events for each
// accepted request into a queue; a monitor pops and checks them as the DUT
// raises its outputs. Honours COIN_500_EN the same way the design does.
module tb_change_dispenser;

  localparam int AW          = 4;
  localparam int ACK_TIMEOUT = 8;
  localparam int GAP_CYCLES  = 3;
  localparam int K_DONE      = 0;
  localparam int K_FAULT     = 99;

  typedef struct {
    int kind;  // 1 or 5 for a coin, K_DONE, K_FAULT
    int rem;   // remaining shown by the DUT when the event appears
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          change_valid;
  logic [AW-1:0] change_amount;
  logic          change_ready;
  logic          eject_500;
  logic          eject_100;
  logic          coin_ack;
  logic [AW-1:0] remaining;
  logic          done;
  logic          fault;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   req_count = 0;   // requests issued by stimulus
  int   req_seen  = 0;   // requests whose first event the monitor has seen

  change_dispenser #(
    .AMOUNT_W    (AW),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clock         (clk),
    .reset         (reset),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .change_ready  (change_ready),
    .eject_500     (eject_500),
    .eject_100     (eject_100),
    .coin_ack      (coin_ack),
    .remaining     (remaining),
    .done          (done),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference payout: greedy coin list derived from the amount, one event per
  // coin with the amount still owed, then done (or fault if never acked).
  function automatic int model_push(input int amount, input bit never_ack);
    int   rem = amount;
    int   n   = 0;
    exp_t e;
    if (amount == 0) begin
      e.kind = K_DONE; e.rem = 0; sb_q.push_back(e);
      return 0;
    end
    while (rem > 0) begin
`ifdef COIN_500_EN
      e.kind = (rem >= 5) ? 5 : 1;
`else
      e.kind = 1;
`endif
      e.rem = rem;
      sb_q.push_back(e);
      n++;
      if (never_ack) begin
        e.kind = K_FAULT;
        sb_q.push_back(e);
        return n;
      end
      rem -= e.kind;
    end
    e.kind = K_DONE; e.rem = 0; sb_q.push_back(e);
    return n;
  endfunction

  // ---------------- monitor ----------------
  bit   prev_ej    = 1'b0;
  bit   prev_fault = 1'b0;
  bit   prev_done  = 1'b0;
  int   low_run    = 0;
  int   last_kind  = 0;
  int   last_rem   = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    bit ej;
    ej = eject_500 || eject_100;
    check_eq("eject_onehot", int'(eject_500 && eject_100), 0);
`ifndef COIN_500_EN
    check_eq("eject_500_unused", int'(eject_500), 0);
`endif
    if (prev_done) check_eq("ready_after_done", int'(change_ready), 1);
    if (ej && !prev_ej) begin
      if (req_count != req_seen) req_seen = req_count;
      else check_eq("gap_len", low_run, GAP_CYCLES);
      check_eq("coin_expected", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check_eq("coin_value", eject_500 ? 5 : 1, mon_e.kind);
        check_eq("remaining_at_eject", int'(remaining), mon_e.rem);
        last_kind = mon_e.kind;
        last_rem  = mon_e.rem;
      end
    end
    if (!ej && prev_ej && !fault && !reset)
      check_eq("remaining_after_ack", int'(remaining), last_rem - last_kind);
    if (done) begin
      if (req_count != req_seen) req_seen = req_count;
      else check_eq("gap_before_done", low_run, GAP_CYCLES);
      check_eq("done_expected", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check_eq("done_event", K_DONE, mon_e.kind);
        check_eq("remaining_at_done", int'(remaining), mon_e.rem);
      end
    end
    if (fault && !prev_fault) begin
      check_eq("fault_expected", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check_eq("fault_event", K_FAULT, mon_e.kind);
        check_eq("remaining_at_fault", int'(remaining), mon_e.rem);
      end
    end
    low_run    = ej ? 0 : low_run + 1;
    prev_ej    = ej;
    prev_fault = fault;
    prev_done  = done;
  end

  // ---------------- stimulus ----------------
  // Issues one request and plays the coin mechanism until the expected events
  // are consumed. With noise, issues ignored requests (amount 9) and stray acks
  // while coins are still owed.
  task automatic run_txn(input int amount, input int ack_delay, input bit never_ack,
                         input bit noise, input bit abort_in_eject, output int eject_run);
    int hi_cnt     = 0;
    int last_run   = 0;
    int cyc        = 0;
    int coins_left;
    $display("txn amount=%0d ack_delay=%0d never_ack=%0d noise=%0d abort=%0d",
             amount, ack_delay, never_ack, noise, abort_in_eject);
    while (!change_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("ready_before_request", int'(change_ready), 1);
    coins_left = model_push(amount, never_ack);
    req_count++;
    change_valid  = 1'b1;
    change_amount = AW'(amount);
    @(negedge clk);
    change_valid  = 1'b0;
    change_amount = AW'($urandom);
    check_eq("accept_latency", int'(eject_500 || eject_100), int'(amount != 0));
    if (amount == 0) begin
      check_eq("zero_done_n1", int'(done), 1);
      check_eq("zero_ready_n1", int'(change_ready), 0);
      @(negedge clk);
      check_eq("zero_done_n2", int'(done), 0);
      check_eq("zero_ready_n2", int'(change_ready), 1);
    end
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 600) begin
      if (eject_500 || eject_100) begin
        hi_cnt++;
        if (abort_in_eject && hi_cnt == 2) begin
          coin_ack     = 1'b0;
          change_valid = 1'b0;
          eject_run    = hi_cnt;
          return;
        end
        coin_ack = !never_ack && (hi_cnt == ack_delay + 1);
        if (coin_ack) coins_left--;
      end else begin
        if (hi_cnt != 0) last_run = hi_cnt;
        hi_cnt   = 0;
        coin_ack = noise && (coins_left > 0) && ($urandom_range(0, 1) == 1);
      end
      change_valid  = noise && (coins_left > 0) && ($urandom_range(0, 2) == 0);
      change_amount = noise ? AW'(9) : AW'($urandom);
      @(negedge clk);
      cyc++;
    end
    coin_ack     = 1'b0;
    change_valid = 1'b0;
    eject_run    = (hi_cnt != 0) ? hi_cnt : last_run;
    if (sb_q.size() != 0) begin
      check_eq("payout_events_left", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic check_idle_values(input string tag);
    check_eq({tag, "_ready"},     int'(change_ready), 1);
    check_eq({tag, "_eject_500"}, int'(eject_500), 0);
    check_eq({tag, "_eject_100"}, int'(eject_100), 0);
    check_eq({tag, "_remaining"}, int'(remaining), 0);
    check_eq({tag, "_done"},      int'(done), 0);
    check_eq({tag, "_fault"},     int'(fault), 0);
  endtask

  initial begin
    int run;
    reset         = 1'b1;
    change_valid  = 1'b0;
    change_amount = '0;
    coin_ack      = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_values("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_txn(7, 2, 1'b0, 1'b0, 1'b0, run);
    run_txn(0, 0, 1'b0, 1'b0, 1'b0, run);
    run_txn(2, 1, 1'b0, 1'b1, 1'b0, run);
    run_txn(6, 0, 1'b0, 1'b0, 1'b0, run);
    run_txn(1, 7, 1'b0, 1'b0, 1'b0, run);   // ack on the timeout cycle wins
    run_txn(15, 3, 1'b0, 1'b1, 1'b0, run);

    // Randomised payouts.
    for (int i = 0; i < 12; i++) begin
      run_txn(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 1'b0,
              bit'($urandom_range(0, 1)), 1'b0, run);
    end

    // Reset in the middle of an eject, then a normal payout.
    run_txn(3, 5, 1'b0, 1'b0, 1'b1, run);
    reset = 1'b1;
    @(negedge clk);
    check_idle_values("midreset");
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    run_txn(1, 1, 1'b0, 1'b0, 1'b0, run);

    // Ack never arrives: timeout, sticky fault, requests ignored.
    run_txn(7, 0, 1'b1, 1'b0, 1'b0, run);
    check_eq("timeout_eject_cycles", run, ACK_TIMEOUT);
    for (int i = 0; i < 5; i++) begin
      change_valid  = 1'b1;
      change_amount = AW'($urandom_range(1, 15));
      @(negedge clk);
      check_eq("fault_sticky",    int'(fault), 1);
      check_eq("fault_not_ready", int'(change_ready), 0);
      check_eq("fault_remaining", int'(remaining), 7);
      check_eq("fault_ejects",    int'(eject_500 || eject_100), 0);
    end
    change_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_idle_values("fault_reset");
    reset = 1'b0;
    @(negedge clk);
    run_txn(5, 2, 1'b0, 1'b0, 1'b0, run);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
